bigmul_job_ctrl: RTL and testbench
==================================

BIGMUL_JOB_CTRL -- requirements
Module: bigmul_job_ctrl

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 1024, the maximum number of cycles spent in WAIT before a job aborts.
REQ-002 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-003 rstn  in  1  reset, asynchronous and active-low.
REQ-004 req  in  2  per-requester job request, level.
REQ-005 grant  out  2  one-hot owner of the multiplier; all-zero when free.
REQ-006 in_valid / in_ready / in_data  in / out / 64  operand stream from the granted requester: 64 A words, then 64 B words, LSW first.
REQ-007 out_valid / out_ready / out_data / out_idx / out_last  out / in / out 64 / out 7 / out 1  result stream of 128 words, LSW first.
REQ-008 err  out  1  one-cycle pulse on a job timeout.
REQ-009 mul_wr_en / mul_wr_sel / mul_wr_addr / mul_wr_data  out  1 / 1 / 6 / 64  operand-cache write port (sel 0=A, 1=B).
REQ-010 mul_start  out  1  one-cycle start pulse to the multiplier.
REQ-011 mul_busy / mul_done  in  1 / 1  multiplier status; mul_done is a level, cleared by the multiplier on the edge that samples mul_start.
REQ-012 mul_rd_addr / mul_rd_data  out 7 / in 64  result-cache read port, combinational read.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, START, WAIT, DRAIN and RELEASE.
REQ-014 In IDLE with req != 0, the controller SHALL register grant by round-robin: the requester not served last wins a tie, and the sole requester wins otherwise; next state LOAD, with ld_cnt=0.
REQ-015 In IDLE with req == 0, the controller SHALL stay in IDLE with grant=0.
REQ-016 In LOAD, in_ready SHALL be 1, and it SHALL be 0 in every other state.
REQ-017 On each LOAD beat (in_valid & in_ready), mul_wr_en SHALL be 1 combinationally in the same cycle, with mul_wr_data=in_data, mul_wr_addr=ld_cnt[5:0] and mul_wr_sel=ld_cnt[6]; ld_cnt SHALL then increment.
REQ-018 mul_wr_en SHALL be 0 outside LOAD beats, and in_valid gaps SHALL stall loading without losing count.
REQ-019 The beat with ld_cnt=127 SHALL move the FSM to START, which takes exactly 128 beats.
REQ-020 START SHALL assert mul_start for exactly one cycle, then go to WAIT with wait_cnt=0.
REQ-021 In WAIT, mul_start SHALL be 0, wait_cnt SHALL increment each cycle, and mul_done=1 SHALL move the FSM to DRAIN with rd_cnt=0.
REQ-022 If wait_cnt reaches TIMEOUT_CYCLES-1 without mul_done, the controller SHALL pulse err for 1 cycle and go to RELEASE with no drain.
REQ-023 If mul_done and the timeout occur in the same cycle, mul_done SHALL win.
REQ-024 In DRAIN, the controller SHALL drive mul_rd_addr=rd_cnt, out_valid=1, out_data=mul_rd_data, out_idx=rd_cnt and out_last=(rd_cnt==127).
REQ-025 In DRAIN, the out_* signals SHALL hold stable while out_ready=0, and rd_cnt SHALL advance only on out_valid & out_ready.
REQ-026 The handshake with out_last=1 SHALL move the FSM to RELEASE.
REQ-027 RELEASE SHALL clear grant, record the served requester as last, and return to IDLE; a new grant is possible on the following cycle.
REQ-028 grant SHALL remain constant from IDLE exit to RELEASE; deassertion of req mid-job SHALL be ignored, and the job SHALL complete.
REQ-029 mul_busy SHALL be used only as an assertion check: mul_start SHALL never be driven while mul_busy=1.
REQ-030 Counters SHALL be exact-width (ld_cnt and rd_cnt 7-bit, wait_cnt sized for TIMEOUT_CYCLES) and SHALL not wrap within a job.

Reset
REQ-031 rstn=0 SHALL force, asynchronously, state=IDLE, grant=0, last=1 (requester 0 served first), all counters=0, and in_ready=out_valid=out_last=err=mul_wr_en=mul_start=0.
REQ-032 Reset mid-job SHALL abandon the job with no further writes or start pulses; resetting the multiplier is the system's responsibility.

Verification
REQ-033 Single job: req=01 with A[i]=i+1 and B[i]=1 for all i, and the multiplier model done 300 cycles after start -> grant=01, 128 writes, 1 mul_start pulse, and 128 results with idx 0..127 and out_last at idx 127.
REQ-034 Contention: req=11 held from reset -> the jobs are served in order requester 0, then 1, then 0, with grant never 11 and at least 1 idle cycle between grants.
REQ-035 Backpressure: random in_valid gaps plus out_ready low for 5 cycles at idx 40 -> no write lost or duplicated, and out_data/out_idx stable while stalled.
REQ-036 Timeout: TIMEOUT_CYCLES=16 with mul_done never asserting -> err pulses once 16 cycles after START, there is no out_valid, and grant clears.
REQ-037 Reset mid-LOAD at beat 50, then rstn=1 with req=10 -> immediate IDLE, and the next grant=10 restarts with ld_cnt=0.
REQ-038 Simultaneous timeout and mul_done in the same cycle -> DRAIN is entered and err stays 0.

Source files
------------

// File: rtl/bigmul_job_ctrl.sv
// Job controller for a shared 4096x4096-bit multiplier.
// Arbitrates two requesters round-robin, streams 128 operand words into the
// multiplier's operand cache, fires a single start pulse, waits for completion
// under a timeout, then streams the 128 result words back out.
module bigmul_job_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req,
  output logic [1:0]  grant,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [6:0]  out_idx,
  output logic        out_last,
  output logic        err,
  output logic        mul_wr_en,
  output logic        mul_wr_sel,
  output logic [5:0]  mul_wr_addr,
  output logic [63:0] mul_wr_data,
  output logic        mul_start,
  input  logic        mul_busy,
  input  logic        mul_done,
  output logic [6:0]  mul_rd_addr,
  input  logic [63:0] mul_rd_data
);

  localparam int                WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DRAIN,
    ST_RELEASE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_grant;
  logic              r_last;      // index of the requester served most recently
  logic [6:0]        r_ld_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [6:0]        r_rd_cnt;

  logic              w_ld_beat;
  logic              w_out_beat;
  logic              w_timeout;
  logic [1:0]        w_pick;

  assign w_ld_beat  = (r_state == ST_LOAD) && in_valid;
  assign w_out_beat = (r_state == ST_DRAIN) && out_ready;
  // A completion arriving on the final wait cycle takes priority over the abort.
  assign w_timeout  = (r_state == ST_WAIT) && !mul_done && (r_wait_cnt == WAIT_LAST);

  // On a tie the requester that was not served last wins; otherwise the sole requester.
  assign w_pick = (req == 2'b11) ? (r_last ? 2'b01 : 2'b10)
                                 : (req[0] ? 2'b01 : 2'b10);

  assign grant       = r_grant;
  assign in_ready    = (r_state == ST_LOAD);
  assign mul_wr_en   = w_ld_beat;
  assign mul_wr_sel  = r_ld_cnt[6];
  assign mul_wr_addr = r_ld_cnt[5:0];
  assign mul_wr_data = in_data;
  assign mul_start   = (r_state == ST_START);
  assign err         = w_timeout;
  assign out_valid   = (r_state == ST_DRAIN);
  assign out_data    = mul_rd_data;
  assign out_idx     = r_rd_cnt;
  assign out_last    = (r_state == ST_DRAIN) && (r_rd_cnt == 7'd127);
  assign mul_rd_addr = r_rd_cnt;

  // Job sequencing: arbitration, operand load, start, wait, drain, release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_last     <= 1'b1;
      r_ld_cnt   <= '0;
      r_wait_cnt <= '0;
      r_rd_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on
      // pre-edge values, so the order of statements below does not matter.
      unique case (r_state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            r_grant  <= w_pick;
            r_ld_cnt <= '0;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_ld_beat) begin
            if (r_ld_cnt == 7'd127) begin
              r_ld_cnt <= '0;
              r_state  <= ST_START;
            end else begin
              r_ld_cnt <= r_ld_cnt + 7'd1;
            end
          end
        end
        ST_START: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mul_done) begin
            r_rd_cnt <= '0;
            r_state  <= ST_DRAIN;
          end else if (w_timeout) begin
            r_state  <= ST_RELEASE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (w_out_beat) begin
            if (r_rd_cnt == 7'd127) begin
              r_rd_cnt <= '0;
              r_state  <= ST_RELEASE;
            end else begin
              r_rd_cnt <= r_rd_cnt + 7'd1;
            end
          end
        end
        ST_RELEASE: begin
          r_last  <= r_grant[1];
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The multiplier must never see a start pulse while it is still computing.
  a_no_start_while_busy : assert property (@(posedge clk) disable iff (!rstn)
    !(mul_start && mul_busy));

endmodule

// File: tb/tb_bigmul_job_ctrl.sv
// Directed bench for bigmul_job_ctrl. Two instances share the stimulus: one
// with the default timeout for the data-path jobs, one with a 16-cycle
// timeout for the abort and done-versus-timeout boundary cases.
module tb_bigmul_job_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req, req_to;
  logic        in_valid, out_ready;
  logic [63:0] in_data;
  logic        mul_busy, mul_done, mul_done_to;

  logic [1:0]  grant, to_grant;
  logic        in_ready, to_in_ready;
  logic        out_valid, to_out_valid;
  logic [63:0] out_data, to_out_data;
  logic [6:0]  out_idx, to_out_idx;
  logic        out_last, to_out_last;
  logic        err, to_err;
  logic        mul_wr_en, to_mul_wr_en;
  logic        mul_wr_sel, to_mul_wr_sel;
  logic [5:0]  mul_wr_addr, to_mul_wr_addr;
  logic [63:0] mul_wr_data, to_mul_wr_data;
  logic        mul_start, to_mul_start;
  logic [6:0]  mul_rd_addr, to_mul_rd_addr;
  logic [63:0] mul_rd_data, to_mul_rd_data;

  // Operand word sent at load index i: A[i]=i+1, B[i]=1.
  function automatic logic [63:0] word_of(input int i);
    return (i < 64) ? 64'(i + 1) : 64'd1;
  endfunction

  // Result-cache contents presented by the multiplier model.
  function automatic logic [63:0] res_of(input logic [6:0] i);
    return {32'hD00D_F00D ^ 32'(i), 32'(i) * 32'd3 + 32'd7};
  endfunction

  assign mul_rd_data    = res_of(mul_rd_addr);
  assign to_mul_rd_data = res_of(to_mul_rd_addr);

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  bigmul_job_ctrl dut (
    .clk(clk), .rstn(rstn), .req(req), .grant(grant),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .err(err),
    .mul_wr_en(mul_wr_en), .mul_wr_sel(mul_wr_sel), .mul_wr_addr(mul_wr_addr),
    .mul_wr_data(mul_wr_data), .mul_start(mul_start), .mul_busy(mul_busy),
    .mul_done(mul_done), .mul_rd_addr(mul_rd_addr), .mul_rd_data(mul_rd_data)
  );

  bigmul_job_ctrl #(.TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .rstn(rstn), .req(req_to), .grant(to_grant),
    .in_valid(in_valid), .in_ready(to_in_ready), .in_data(in_data),
    .out_valid(to_out_valid), .out_ready(out_ready), .out_data(to_out_data),
    .out_idx(to_out_idx), .out_last(to_out_last), .err(to_err),
    .mul_wr_en(to_mul_wr_en), .mul_wr_sel(to_mul_wr_sel), .mul_wr_addr(to_mul_wr_addr),
    .mul_wr_data(to_mul_wr_data), .mul_start(to_mul_start), .mul_busy(1'b0),
    .mul_done(mul_done_to), .mul_rd_addr(to_mul_rd_addr), .mul_rd_data(to_mul_rd_data)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Stimulus / model state.
  int ld_drv, done_delay, done_timer;
  bit gappy, bp_mode, armed, pend_start;

  // Main-instance observations.
  int          n_wr, n_start, n_out, n_err, n_jobs, n_bad_grant, stall_cycles;
  logic [63:0] cache_a [64];
  logic [63:0] cache_b [64];
  int          hits_a [64];
  int          hits_b [64];
  logic [1:0]  prev_grant;
  logic [1:0]  grant_q [$];
  bit          have_fall;
  int          fall_cyc, min_gap, n_gaps;

  // Short-timeout instance observations.
  int to_n_wr, to_n_start, to_n_err, to_n_outv, to_n_out, to_n_last;
  int to_start_cyc, to_err_cyc, to_first_outv_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic clear_counts();
    n_wr = 0; n_start = 0; n_out = 0; n_err = 0; n_jobs = 0; n_bad_grant = 0; stall_cycles = 0;
    for (int i = 0; i < 64; i++) begin
      cache_a[i] = '0; cache_b[i] = '0; hits_a[i] = 0; hits_b[i] = 0;
    end
    grant_q.delete();
    prev_grant = grant; have_fall = 0; fall_cyc = 0; min_gap = 1000; n_gaps = 0;
    to_n_wr = 0; to_n_start = 0; to_n_err = 0; to_n_outv = 0; to_n_out = 0; to_n_last = 0;
    to_start_cyc = 0; to_err_cyc = 0; to_first_outv_cyc = -1;
  endtask

  // One clock cycle, entered and left at a falling edge: drive, settle, observe.
  task automatic cycle();
    if (pend_start) begin
      pend_start = 0; armed = 1; done_timer = done_delay - 1; mul_done = 0;
    end else if (armed && done_timer > 0) begin
      done_timer--;
    end
    if (armed && done_timer == 0) mul_done = 1;
    mul_busy = armed && !mul_done;
    if (gappy)   in_valid  = ($urandom_range(0, 3) != 0);
    if (bp_mode) out_ready = !(n_out == 40 && stall_cycles < 5);
    in_data = word_of(ld_drv);
    #1;
    if (in_valid && (in_ready || to_in_ready)) ld_drv++;
    if (grant == 2'b00 && to_grant == 2'b00) ld_drv = 0;
    if (mul_wr_en) begin
      n_wr++;
      if (!mul_wr_sel) begin cache_a[mul_wr_addr] = mul_wr_data; hits_a[mul_wr_addr]++; end
      else             begin cache_b[mul_wr_addr] = mul_wr_data; hits_b[mul_wr_addr]++; end
    end
    if (mul_start) begin n_start++; pend_start = 1; end
    if (err) n_err++;
    if (grant == 2'b11) n_bad_grant++;
    if (prev_grant == 2'b00 && grant != 2'b00) begin
      grant_q.push_back(grant);
      if (have_fall) begin
        n_gaps++;
        if (cyc - fall_cyc < min_gap) min_gap = cyc - fall_cyc;
      end
    end
    if (prev_grant != 2'b00 && grant == 2'b00) begin have_fall = 1; fall_cyc = cyc; end
    prev_grant = grant;
    if (out_valid && !out_ready) begin
      stall_cycles++;
      check("stall_idx", 64'(out_idx), 64'd40);
      check("stall_data", out_data, res_of(7'd40));
    end
    if (out_valid && out_ready) begin
      check("out_idx", 64'(out_idx), 64'(n_out % 128));
      check("out_data", out_data, res_of(7'(n_out % 128)));
      check("out_last", 64'(out_last), 64'((n_out % 128) == 127));
      if (out_last) n_jobs++;
      n_out++;
    end
    if (to_mul_wr_en) begin
      check("to_wr_addr", 64'({to_mul_wr_sel, to_mul_wr_addr}), 64'(to_n_wr % 128));
      check("to_wr_data", to_mul_wr_data, word_of(to_n_wr % 128));
      to_n_wr++;
    end
    if (to_mul_start) begin to_n_start++; to_start_cyc = cyc; end
    if (to_err) begin to_n_err++; to_err_cyc = cyc; end
    if (to_out_valid) begin
      to_n_outv++;
      if (to_first_outv_cyc < 0) to_first_outv_cyc = cyc;
    end
    if (to_out_valid && out_ready) begin
      check("to_out_data", to_out_data, res_of(to_out_idx));
      if (to_out_last) to_n_last++;
      to_n_out++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] req_v);
    rstn = 1'b0; req = req_v; req_to = 2'b00; in_valid = 1'b0; out_ready = 1'b1;
    gappy = 0; bp_mode = 0; armed = 0; pend_start = 0;
    mul_done = 1'b0; mul_busy = 1'b0; mul_done_to = 1'b0;
    repeat (3) cycle();
    clear_counts();
    rstn = 1'b1;
  endtask

  task automatic run_until_jobs(input int target, input int budget);
    int k;
    k = 0;
    while (n_jobs < target && k < budget) begin cycle(); k++; end
    check("jobs_done", 64'(n_jobs), 64'(target));
  endtask

  // Full check of one completed job on the main instance.
  task automatic check_job(input logic [1:0] exp_grant);
    logic [1:0] g;
    g = (grant_q.size() > 0) ? grant_q[0] : 2'b00;
    check("first_grant", 64'(g), 64'(exp_grant));
    check("n_wr", 64'(n_wr), 64'd128);
    check("n_start", 64'(n_start), 64'd1);
    check("n_out", 64'(n_out), 64'd128);
    check("n_err", 64'(n_err), 64'd0);
    for (int i = 0; i < 64; i++) begin
      check("a_word", cache_a[i], 64'(i + 1));
      check("b_word", cache_b[i], 64'd1);
      check("a_hits", 64'(hits_a[i]), 64'd1);
      check("b_hits", 64'(hits_b[i]), 64'd1);
    end
  endtask

  initial begin
    int k;
    rstn = 1'b0; req = 2'b01; req_to = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    in_data = '0; mul_done = 1'b0; mul_busy = 1'b0; mul_done_to = 1'b0;
    gappy = 0; bp_mode = 0; armed = 0; pend_start = 0; done_delay = 1; done_timer = 0; ld_drv = 0;
    clear_counts();

    // Reset state with requests and valid data already present.
    @(negedge clk); #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_wr_en", 64'(mul_wr_en), 64'd0);
    check("rst_start", 64'(mul_start), 64'd0);
    check("rst_to_grant", 64'(to_grant), 64'd0);
    @(negedge clk);

    // No requests: stay idle with no grant.
    do_reset(2'b00);
    repeat (2) cycle();
    check("idle_grant", 64'(grant), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd0);

    // Single job from requester 0; request dropped mid-job must not matter.
    done_delay = 300; in_valid = 1'b1; req = 2'b01;
    k = 0;
    while (grant == 2'b00 && k < 10) begin cycle(); k++; end
    req = 2'b00;
    run_until_jobs(1, 2000);
    repeat (3) cycle();
    check_job(2'b01);
    check("single_grant_free", 64'(grant), 64'd0);

    // Contention: both requesting from reset, served 0,1,0 with idle gaps.
    do_reset(2'b11);
    done_delay = 20; in_valid = 1'b1;
    run_until_jobs(3, 3000);
    check("cont_grants", 64'(grant_q.size() >= 3), 64'd1);
    if (grant_q.size() >= 3) begin
      check("cont_g0", 64'(grant_q[0]), 64'b01);
      check("cont_g1", 64'(grant_q[1]), 64'b10);
      check("cont_g2", 64'(grant_q[2]), 64'b01);
    end
    check("cont_bad_grant", 64'(n_bad_grant), 64'd0);
    check("cont_gaps", 64'(n_gaps >= 2), 64'd1);
    check("cont_min_gap", 64'(min_gap >= 1), 64'd1);
    check("cont_n_wr", 64'(n_wr), 64'd384);
    check("cont_n_start", 64'(n_start), 64'd3);

    // Backpressure: random load gaps, 5-cycle output stall at index 40.
    do_reset(2'b10);
    done_delay = 50; gappy = 1; bp_mode = 1;
    run_until_jobs(1, 3000);
    repeat (2) cycle();
    check_job(2'b10);
    check("stall_cycles", 64'(stall_cycles), 64'd5);
    gappy = 0; bp_mode = 0; out_ready = 1'b1;

    // Reset in the middle of the load, then a fresh job for requester 1.
    do_reset(2'b01);
    done_delay = 100; in_valid = 1'b1;
    k = 0;
    while (n_wr < 50 && k < 300) begin cycle(); k++; end
    check("wr_before_reset", 64'(n_wr), 64'd50);
    rstn = 1'b0;
    #1;
    check("async_grant", 64'(grant), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd0);
    check("async_wr_en", 64'(mul_wr_en), 64'd0);
    @(negedge clk);
    armed = 0; pend_start = 0; mul_done = 1'b0;
    repeat (2) cycle();
    check("wr_in_reset", 64'(n_wr), 64'd50);
    check("start_in_reset", 64'(n_start), 64'd0);
    clear_counts();
    req = 2'b10; rstn = 1'b1;
    run_until_jobs(1, 2000);
    repeat (2) cycle();
    check_job(2'b10);

    // Timeout: done never arrives on the 16-cycle instance.
    do_reset(2'b00);
    in_valid = 1'b1; req_to = 2'b01;
    k = 0;
    while (to_n_err == 0 && k < 400) begin
      if (to_grant != 2'b00) req_to = 2'b00;
      cycle(); k++;
    end
    repeat (3) cycle();
    check("to_n_wr", 64'(to_n_wr), 64'd128);
    check("to_n_start", 64'(to_n_start), 64'd1);
    check("to_n_err", 64'(to_n_err), 64'd1);
    check("to_err_delay", 64'(to_err_cyc - to_start_cyc), 64'd16);
    check("to_no_out", 64'(to_n_outv), 64'd0);
    check("to_grant_free", 64'(to_grant), 64'd0);

    // Done arriving on the very cycle the timeout would fire: done wins.
    do_reset(2'b00);
    in_valid = 1'b1; req_to = 2'b10;
    k = 0;
    while (to_n_out < 128 && k < 800) begin
      if (to_grant != 2'b00) req_to = 2'b00;
      mul_done_to = (to_n_start == 1) && (cyc >= to_start_cyc + 16);
      cycle(); k++;
    end
    mul_done_to = 1'b0;
    repeat (3) cycle();
    check("sim_n_err", 64'(to_n_err), 64'd0);
    check("sim_drain_at", 64'(to_first_outv_cyc - to_start_cyc), 64'd17);
    check("sim_n_out", 64'(to_n_out), 64'd128);
    check("sim_n_last", 64'(to_n_last), 64'd1);
    check("sim_grant_free", 64'(to_grant), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
